// File: rtl/clock_fmt_pkg.sv
// clock_fmt_pkg
//   Shared constants for the clock line formatter: line geometry, ASCII codes,
//   BCD field limits, character positions of every field, and small helpers
//   for BCD/ASCII conversion and 24h -> 12h hour mapping.
package clock_fmt_pkg;

  localparam int LINE_CHARS = 16;

  // ASCII characters used on the two lines
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_H     = 8'h48;
  localparam logic [7:0] CH_I     = 8'h49;
  localparam logic [7:0] CH_L     = 8'h4C;
  localparam logic [7:0] CH_M     = 8'h4D;
  localparam logic [7:0] CH_N     = 8'h4E;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_P     = 8'h50;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_U     = 8'h55;
  localparam logic [7:0] CH_Y     = 8'h59;

  // BCD limits of the time fields
  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Character positions (0 = leftmost)
  localparam int POS_LABEL = 0;
  localparam int POS_HH    = 6;
  localparam int POS_C1    = 8;
  localparam int POS_MM    = 9;
  localparam int POS_C2    = 11;
  localparam int POS_SS    = 12;
  localparam int POS_AMPM  = 14;
  localparam int POS_DD    = 4;
  localparam int POS_MODE  = 12;

  // Integer (0..999) to three BCD digits; used for the day limit parameter
  function automatic logic [11:0] int_to_bcd3(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bcd_ascii(input logic [3:0] n);
    return CH_0 + {4'h0, n};
  endfunction

  // 24-hour BCD hour to 12-hour BCD hour (00 -> 12, 13..23 -> 01..11)
  function automatic logic [7:0] hh_to_12h(input logic [7:0] hh);
    logic [4:0] b;
    logic [4:0] t;
    b = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
    if (b == 5'd0) begin
      t = 5'd12;
    end else if (b > 5'd12) begin
      t = b - 5'd12;
    end else begin
      t = b;
    end
    if (t >= 5'd10) begin
      return {4'd1, 4'(t - 5'd10)};
    end else begin
      return {4'd0, t[3:0]};
    end
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
//   Multi-digit BCD counter that wraps to zero after MAX_VAL (BCD encoded).
//   Ports:
//     i_clk       clock
//     i_rst_n     synchronous active-low reset (value -> 0)
//     i_inc       advance by one this cycle
//     i_load      load i_load_val (has priority over i_inc)
//     i_load_val  BCD value to load
//     o_value     current BCD value
//     o_carry     high when i_inc is set and the counter is at MAX_VAL
module bcd_mod_counter #(
  parameter int                    DIGITS  = 2,
  parameter logic [4*DIGITS-1:0]   MAX_VAL = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_inc,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_value,
  output logic                  o_carry
);

  logic [4*DIGITS-1:0] r_value;
  logic [4*DIGITS-1:0] w_inc_val;
  logic [4*DIGITS-1:0] w_next;
  logic                w_ripple;
  logic                w_at_max;

  assign w_at_max = (r_value == MAX_VAL);

  // Plain BCD increment: a digit steps only when every lower digit is 9
  always_comb begin
    w_inc_val = r_value;
    w_ripple  = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_ripple) begin
        if (r_value[d*4 +: 4] == 4'd9) begin
          w_inc_val[d*4 +: 4] = 4'd0;
        end else begin
          w_inc_val[d*4 +: 4] = r_value[d*4 +: 4] + 4'd1;
          w_ripple            = 1'b0;
        end
      end else begin
        w_inc_val[d*4 +: 4] = r_value[d*4 +: 4];
      end
    end
  end

  assign w_next = w_at_max ? '0 : w_inc_val;

  // Value register: load beats increment
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_inc) begin
      r_value <= w_next;
    end else begin
      r_value <= r_value;
    end
  end

  assign o_value = r_value;
  assign o_carry = i_inc && w_at_max;

endmodule

// File: rtl/clock_line_formatter.sv
// clock_line_formatter
//   Keeps BCD time of day and a day counter, advanced by a prescaled mclk, and
//   renders two registered 16-character ASCII lines for the LCD controller.
//   Optional macro: TWELVE_HOUR_EN selects a 12-hour display with AM/PM.
//   Ports:
//     mclk      system clock
//     rst       synchronous active-low reset
//     hold      1 = prescaler frozen, line B shows HOLD
//     set_en    one-cycle load strobe for set_hh/set_mm/set_ss/set_dd (BCD)
//     set_err   one-cycle pulse after a set_en carrying an invalid value
//     sec_tick  one-cycle pulse after each second increment
//     LineA     time line, char i at [i*8+:8]
//     LineB     day/mode line, same packing
module clock_line_formatter
  import clock_fmt_pkg::*;
#(
  parameter int MFREQ_KHZ = 1,
  parameter int DAY_MAX   = 999
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic         hold,
  input  logic         set_en,
  input  logic [7:0]   set_hh,
  input  logic [7:0]   set_mm,
  input  logic [7:0]   set_ss,
  input  logic [11:0]  set_dd,
  output logic         set_err,
  output logic         sec_tick,
  output logic [127:0] LineA,
  output logic [127:0] LineB
);

  localparam int          PRESC_N     = MFREQ_KHZ * 1000;
  localparam int          PW          = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
  localparam logic [11:0] DAY_MAX_BCD = int_to_bcd3(DAY_MAX);

  logic [PW-1:0]  r_presc;
  logic           r_sec_tick;
  logic           r_set_err;
  logic [127:0]   r_line_a;
  logic [127:0]   r_line_b;

  logic           w_tc;
  logic           w_tick;
  logic           w_valid;
  logic           w_load;
  logic           w_adv;
  logic [7:0]     w_ss;
  logic [7:0]     w_mm;
  logic [7:0]     w_hh;
  logic [11:0]    w_dd;
  logic           w_ss_carry;
  logic           w_mm_carry;
  logic           w_hh_carry;
  logic           w_dd_carry_unused;

  function automatic logic [127:0] f_line_a(input logic [7:0] hh,
                                            input logic [7:0] mm,
                                            input logic [7:0] ss);
    logic [127:0] l;
    logic [7:0]   dh;
    l = {LINE_CHARS{CH_SP}};
    l[(POS_LABEL+0)*8 +: 8] = CH_T;
    l[(POS_LABEL+1)*8 +: 8] = CH_I;
    l[(POS_LABEL+2)*8 +: 8] = CH_M;
    l[(POS_LABEL+3)*8 +: 8] = CH_E;
`ifdef TWELVE_HOUR_EN
    dh = hh_to_12h(hh);
    l[POS_AMPM*8 +: 8]     = (hh < 8'h12) ? CH_A : CH_P;
    l[(POS_AMPM+1)*8 +: 8] = CH_M;
`else
    dh = hh;
`endif
    l[POS_HH*8 +: 8]     = bcd_ascii(dh[7:4]);
    l[(POS_HH+1)*8 +: 8] = bcd_ascii(dh[3:0]);
    l[POS_C1*8 +: 8]     = CH_COLON;
    l[POS_MM*8 +: 8]     = bcd_ascii(mm[7:4]);
    l[(POS_MM+1)*8 +: 8] = bcd_ascii(mm[3:0]);
    l[POS_C2*8 +: 8]     = CH_COLON;
    l[POS_SS*8 +: 8]     = bcd_ascii(ss[7:4]);
    l[(POS_SS+1)*8 +: 8] = bcd_ascii(ss[3:0]);
    return l;
  endfunction

  function automatic logic [127:0] f_line_b(input logic [11:0] dd,
                                            input logic        hold_mode);
    logic [127:0] l;
    l = {LINE_CHARS{CH_SP}};
    l[(POS_LABEL+0)*8 +: 8] = CH_D;
    l[(POS_LABEL+1)*8 +: 8] = CH_A;
    l[(POS_LABEL+2)*8 +: 8] = CH_Y;
    l[POS_DD*8 +: 8]        = bcd_ascii(dd[11:8]);
    l[(POS_DD+1)*8 +: 8]    = bcd_ascii(dd[7:4]);
    l[(POS_DD+2)*8 +: 8]    = bcd_ascii(dd[3:0]);
    if (hold_mode) begin
      l[POS_MODE*8 +: 32] = {CH_D, CH_L, CH_O, CH_H};
    end else begin
      l[POS_MODE*8 +: 32] = {CH_SP, CH_N, CH_U, CH_R};
    end
    return l;
  endfunction

  // Prescaler terminal count; a frozen prescaler never ticks
  assign w_tc   = (r_presc == PW'(PRESC_N - 1));
  assign w_tick = !hold && w_tc;

  // BCD ordering matches numeric ordering once every nibble is a digit
  assign w_valid = (set_hh[7:4] <= 4'd9) && (set_hh[3:0] <= 4'd9) &&
                   (set_mm[7:4] <= 4'd9) && (set_mm[3:0] <= 4'd9) &&
                   (set_ss[7:4] <= 4'd9) && (set_ss[3:0] <= 4'd9) &&
                   (set_dd[11:8] <= 4'd9) && (set_dd[7:4] <= 4'd9) &&
                   (set_dd[3:0] <= 4'd9) &&
                   (set_hh <= HH_MAX) && (set_mm <= MS_MAX) &&
                   (set_ss <= MS_MAX) && (set_dd <= DAY_MAX_BCD);

  assign w_load = set_en && w_valid;
  // A load in the tick cycle swallows that tick
  assign w_adv  = w_tick && !w_load;

  // Prescaler: cleared by a valid load, frozen by hold, wraps at terminal count
  always_ff @(posedge mclk) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_load) begin
      r_presc <= '0;
    end else if (hold) begin
      r_presc <= r_presc;
    end else if (w_tc) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  bcd_mod_counter #(.DIGITS(2), .MAX_VAL(MS_MAX)) u_ss (
    .i_clk(mclk), .i_rst_n(rst), .i_inc(w_adv), .i_load(w_load),
    .i_load_val(set_ss), .o_value(w_ss), .o_carry(w_ss_carry)
  );

  bcd_mod_counter #(.DIGITS(2), .MAX_VAL(MS_MAX)) u_mm (
    .i_clk(mclk), .i_rst_n(rst), .i_inc(w_ss_carry), .i_load(w_load),
    .i_load_val(set_mm), .o_value(w_mm), .o_carry(w_mm_carry)
  );

  bcd_mod_counter #(.DIGITS(2), .MAX_VAL(HH_MAX)) u_hh (
    .i_clk(mclk), .i_rst_n(rst), .i_inc(w_mm_carry), .i_load(w_load),
    .i_load_val(set_hh), .o_value(w_hh), .o_carry(w_hh_carry)
  );

  bcd_mod_counter #(.DIGITS(3), .MAX_VAL(DAY_MAX_BCD)) u_dd (
    .i_clk(mclk), .i_rst_n(rst), .i_inc(w_hh_carry), .i_load(w_load),
    .i_load_val(set_dd), .o_value(w_dd), .o_carry(w_dd_carry_unused)
  );

  // Status pulses, one cycle after the event
  always_ff @(posedge mclk) begin
    if (!rst) begin
      r_sec_tick <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_sec_tick <= w_adv;
      r_set_err  <= set_en && !w_valid;
    end
  end

  // Both lines are rebuilt on the same edge from the counter registers
  always_ff @(posedge mclk) begin
    if (!rst) begin
      r_line_a <= f_line_a(8'h00, 8'h00, 8'h00);
      r_line_b <= f_line_b(12'h000, 1'b0);
    end else begin
      r_line_a <= f_line_a(w_hh, w_mm, w_ss);
      r_line_b <= f_line_b(w_dd, hold);
    end
  end

  assign sec_tick = r_sec_tick;
  assign set_err  = r_set_err;
  assign LineA    = r_line_a;
  assign LineB    = r_line_b;

endmodule

// File: tb/tb_clock_line_formatter.sv
// Directed self-checking bench for clock_line_formatter (MFREQ_KHZ=1, so one
// second is 1000 mclk cycles). Inputs change on the falling edge, outputs are
// sampled on the falling edge. Build with +define+TWELVE_HOUR_EN for the
// 12-hour display variant; expectations switch accordingly.
module tb_clock_line_formatter;

  logic         mclk = 1'b0;
  logic         rst;
  logic         hold;
  logic         set_en;
  logic [7:0]   set_hh;
  logic [7:0]   set_mm;
  logic [7:0]   set_ss;
  logic [11:0]  set_dd;
  logic         set_err;
  logic         sec_tick;
  logic [127:0] LineA;
  logic [127:0] LineB;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;

  clock_line_formatter #(.MFREQ_KHZ(1), .DAY_MAX(999)) dut (
    .mclk(mclk), .rst(rst), .hold(hold), .set_en(set_en),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_dd(set_dd),
    .set_err(set_err), .sec_tick(sec_tick), .LineA(LineA), .LineB(LineB)
  );

  always #5 mclk = ~mclk;

  // 16-char text to the line packing (char 0 in the low byte)
  function automatic logic [127:0] pk(input string s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] la(input string s24, input string s12);
`ifdef TWELVE_HOUR_EN
    return pk(s12);
`else
    return pk(s24);
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge mclk);
      @(negedge mclk);
      tick_cnt += int'(sec_tick);
    end
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s, input logic [11:0] d);
    set_hh = h; set_mm = m; set_ss = s; set_dd = d;
    set_en = 1'b1;
    run(1);
    set_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; hold = 1'b0; set_en = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00; set_dd = 12'h000;
    run(3);
    chk("rst_linea", LineA, la("TIME  00:00:00  ", "TIME  12:00:00AM"));
    chk("rst_lineb", LineB, pk("DAY 000     RUN "));
    chk("rst_tick", 128'(sec_tick), 128'(0));
    chk("rst_err", 128'(set_err), 128'(0));

    // first second after reset
    rst = 1'b1;
    tick_cnt = 0;
    run(999);
    chk("pre_tick_cnt", 128'(tick_cnt), 128'(0));
    chk("pre_tick_linea", LineA, la("TIME  00:00:00  ", "TIME  12:00:00AM"));
    run(1);
    chk("first_tick", 128'(sec_tick), 128'(1));
    run(2);
    chk("sec1_linea", LineA, la("TIME  00:00:01  ", "TIME  12:00:01AM"));
    chk("sec1_lineb", LineB, pk("DAY 000     RUN "));
    chk("sec1_cnt", 128'(tick_cnt), 128'(1));

    // full carry chain into the day counter
    do_set(8'h23, 8'h59, 8'h59, 12'h041);
    chk("valid_no_err", 128'(set_err), 128'(0));
    tick_cnt = 0;
    run(2);
    chk("load_linea", LineA, la("TIME  23:59:59  ", "TIME  11:59:59PM"));
    chk("load_lineb", LineB, pk("DAY 041     RUN "));
    run(997);
    chk("carry_pre_cnt", 128'(tick_cnt), 128'(0));
    run(1);
    chk("carry_tick", 128'(sec_tick), 128'(1));
    run(2);
    chk("carry_linea", LineA, la("TIME  00:00:00  ", "TIME  12:00:00AM"));
    chk("carry_lineb", LineB, pk("DAY 042     RUN "));
    chk("carry_cnt", 128'(tick_cnt), 128'(1));

    // day wrap at DAY_MAX
    do_set(8'h23, 8'h59, 8'h59, 12'h999);
    run(1002);
    chk("wrap_linea", LineA, la("TIME  00:00:00  ", "TIME  12:00:00AM"));
    chk("wrap_lineb", LineB, pk("DAY 000     RUN "));

    // hold freezes the prescaler at 2
    hold = 1'b1;
    tick_cnt = 0;
    run(5000);
    chk("hold_cnt", 128'(tick_cnt), 128'(0));
    chk("hold_linea", LineA, la("TIME  00:00:00  ", "TIME  12:00:00AM"));
    chk("hold_lineb", LineB, pk("DAY 000     HOLD"));
    hold = 1'b0;
    run(997);
    chk("resume_pre_cnt", 128'(tick_cnt), 128'(0));
    chk("resume_lineb", LineB, pk("DAY 000     RUN "));
    run(1);
    chk("resume_tick", 128'(sec_tick), 128'(1));
    run(2);
    chk("resume_linea", LineA, la("TIME  00:00:01  ", "TIME  12:00:01AM"));

    // invalid loads
    do_set(8'h24, 8'h00, 8'h00, 12'h000);
    chk("bad_hh_err", 128'(set_err), 128'(1));
    run(1);
    chk("bad_hh_err_end", 128'(set_err), 128'(0));
    chk("bad_hh_linea", LineA, la("TIME  00:00:01  ", "TIME  12:00:01AM"));
    do_set(8'h10, 8'h5A, 8'h00, 12'h000);
    chk("bad_mm_err", 128'(set_err), 128'(1));
    run(2);
    chk("bad_mm_linea", LineA, la("TIME  00:00:01  ", "TIME  12:00:01AM"));
    chk("bad_mm_lineb", LineB, pk("DAY 000     RUN "));
    do_set(8'h01, 8'h02, 8'h60, 12'h000);
    chk("bad_ss_err", 128'(set_err), 128'(1));

    // load on the terminal prescaler cycle
    do_set(8'h10, 8'h20, 8'h30, 12'h005);
    tick_cnt = 0;
    run(999);
    do_set(8'h05, 8'h06, 8'h07, 12'h123);
    chk("coinc_no_tick", 128'(sec_tick), 128'(0));
    run(2);
    chk("coinc_linea", LineA, la("TIME  05:06:07  ", "TIME  05:06:07AM"));
    chk("coinc_lineb", LineB, pk("DAY 123     RUN "));
    run(997);
    chk("coinc_cnt", 128'(tick_cnt), 128'(0));
    run(1);
    chk("coinc_next_tick", 128'(sec_tick), 128'(1));
    run(2);
    chk("coinc_next_linea", LineA, la("TIME  05:06:08  ", "TIME  05:06:08AM"));

    // load while held, hour display forms
    hold = 1'b1;
    do_set(8'h00, 8'h05, 8'h00, 12'h000);
    run(2);
    chk("h00_linea", LineA, la("TIME  00:05:00  ", "TIME  12:05:00AM"));
    do_set(8'h13, 8'h00, 8'h00, 12'h000);
    run(2);
    chk("h13_linea", LineA, la("TIME  13:00:00  ", "TIME  01:00:00PM"));
    do_set(8'h12, 8'h30, 8'h00, 12'h000);
    run(2);
    chk("h12_linea", LineA, la("TIME  12:30:00  ", "TIME  12:30:00PM"));
    chk("h12_lineb", LineB, pk("DAY 000     HOLD"));
    hold = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
